// File: rtl/icache_direct.sv
// Direct-mapped, read-only instruction cache. Hits are answered in the request cycle;
// a miss refills the whole two-word block from memory before serving the fetch.
module icache_direct #(
    parameter int SETS = 16
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        imemREN,
    input  logic [31:0] imemaddr,
    output logic        ihit,
    output logic [31:0] imemload,
    output logic        iREN,
    output logic [31:0] iaddr,
    input  logic        iwait,
    input  logic [31:0] iload,
    output logic [31:0] hit_count,
    output logic [31:0] miss_count,
    output logic [1:0]  fsm_state
);

    localparam int IDX_W = $clog2(SETS);
    localparam int TAG_W = 29 - IDX_W;

    // Memory handshake: iREN/iaddr are held while iwait=1; the word in iload is
    // consumed on the rising edge where iREN=1 and iwait=0.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FETCH0 = 2'd1,
        FETCH1 = 2'd2
    } state_t;

    state_t state;

    logic [SETS-1:0]  valid;
    logic [TAG_W-1:0] tag_mem   [SETS];
    logic [31:0]      word0_mem [SETS];
    logic [31:0]      word1_mem [SETS];

    logic [31:0]      refill_buf;
    logic [TAG_W-1:0] miss_tag;
    logic [IDX_W-1:0] miss_idx;

    logic [TAG_W-1:0] req_tag;
    logic [IDX_W-1:0] req_idx;
    logic             req_word;
    logic             lookup_hit;
    logic             fill_done;
    logic             unused_byte_bits;

    assign req_tag          = imemaddr[31:3+IDX_W];
    assign req_idx          = imemaddr[2+IDX_W:3];
    assign req_word         = imemaddr[2];
    assign unused_byte_bits = ^imemaddr[1:0];

    assign lookup_hit = valid[req_idx] && (tag_mem[req_idx] == req_tag);
    assign ihit       = (state == IDLE) && imemREN && lookup_hit;
    assign imemload   = ihit ? (req_word ? word1_mem[req_idx] : word0_mem[req_idx]) : 32'h0;
    assign fill_done  = (state == FETCH1) && !iwait;
    assign fsm_state  = state;

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state      <= IDLE;
            valid      <= '0;
            refill_buf <= 32'h0;
            miss_tag   <= '0;
            miss_idx   <= '0;
            iREN       <= 1'b0;
            iaddr      <= 32'h0;
            hit_count  <= 32'h0;
            miss_count <= 32'h0;
        end else begin
            if (ihit && (hit_count != 32'hFFFF_FFFF)) begin
                hit_count <= hit_count + 32'd1;
            end
            case (state)
                IDLE: begin
                    if (imemREN && !lookup_hit) begin
                        miss_tag <= req_tag;
                        miss_idx <= req_idx;
                        if (miss_count != 32'hFFFF_FFFF) begin
                            miss_count <= miss_count + 32'd1;
                        end
                        iREN  <= 1'b1;
                        iaddr <= {req_tag, req_idx, 1'b0, 2'b00};
                        state <= FETCH0;
                    end
                end
                FETCH0: begin
                    if (!iwait) begin
                        refill_buf <= iload;
                        iaddr      <= {miss_tag, miss_idx, 1'b1, 2'b00};
                        state      <= FETCH1;
                    end
                end
                FETCH1: begin
                    if (!iwait) begin
                        valid[miss_idx] <= 1'b1;
                        iREN            <= 1'b0;
                        iaddr           <= 32'h0;
                        state           <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                    iREN  <= 1'b0;
                    iaddr <= 32'h0;
                end
            endcase
        end
    end

    // Frame payload needs no reset: a frame is only read once its valid bit is set.
    always_ff @(posedge CLK) begin
        if (nRST && fill_done) begin
            tag_mem[miss_idx]   <= miss_tag;
            word0_mem[miss_idx] <= refill_buf;
            word1_mem[miss_idx] <= iload;
        end
    end

endmodule

// File: tb/tb_icache_direct.sv
// Bench for icache_direct: directed vector table, hand-written reset sequences and
// randomized fetches checked against a frame-level model of the cache.
module tb_icache_direct;

    logic        CLK = 1'b0;
    logic        nRST;
    logic        imemREN;
    logic [31:0] imemaddr;
    logic        ihit;
    logic [31:0] imemload;
    logic        iREN;
    logic [31:0] iaddr;
    logic        iwait;
    logic [31:0] iload;
    logic [31:0] hit_count;
    logic [31:0] miss_count;
    logic [1:0]  fsm_state;

    int tests = 0;
    int fails = 0;

    // Reference model: which block each frame holds, plus event counts.
    bit          m_valid [16];
    logic [24:0] m_tag   [16];
    int          m_hits;
    int          m_misses;
    logic [31:0] exp_q[$];

    typedef struct {
        logic [31:0] addr;
        int          w0;
        int          w1;
        int          mode;
        logic [31:0] alt;
        bit          exp_hit;
        int          exp_mc;
    } vec_t;

    vec_t vecs [11];

    icache_direct #(.SETS(16)) dut (
        .CLK        (CLK),
        .nRST       (nRST),
        .imemREN    (imemREN),
        .imemaddr   (imemaddr),
        .ihit       (ihit),
        .imemload   (imemload),
        .iREN       (iREN),
        .iaddr      (iaddr),
        .iwait      (iwait),
        .iload      (iload),
        .hit_count  (hit_count),
        .miss_count (miss_count),
        .fsm_state  (fsm_state)
    );

    always #5 CLK = ~CLK;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return 32'hAAAA_0000 ^ a;
    endfunction

    assign iload = iREN ? mem_word(iaddr) : 32'hDEAD_BEEF;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
        m_hits   = 0;
        m_misses = 0;
        exp_q.delete();
    endtask

    task automatic apply_reset();
        @(negedge CLK);
        nRST    = 1'b0;
        imemREN = 1'b0;
        iwait   = 1'b1;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        nRST = 1'b1;
        model_clear();
    endtask

    task automatic idle_cycle();
        @(negedge CLK);
        imemREN  = 1'b0;
        imemaddr = $urandom;
        iwait    = 1'b1;
        #1;
        check("ihit_noreq", ihit, 0);
        check("imemload_noreq", imemload, 0);
        check("iREN_noreq", iREN, 0);
        @(posedge CLK);
    endtask

    // mode 0: plain fetch; 1: redirect imemaddr to alt during FETCH0;
    // 2: drop imemREN during FETCH0. Modes 1/2 return right after the refill.
    task automatic do_fetch(input logic [31:0] addr, input int w0, input int w1,
                            input int mode, input logic [31:0] alt, output bit was_hit);
        logic [31:0] blk;
        logic [31:0] exp_a;
        int          idx;
        logic [24:0] tag;
        bit          exp_hit;
        int          w;
        blk     = {addr[31:3], 3'b000};
        idx     = int'(addr[6:3]);
        tag     = addr[31:7];
        exp_hit = m_valid[idx] && (m_tag[idx] == tag);
        @(negedge CLK);
        imemREN  = 1'b1;
        imemaddr = addr;
        iwait    = 1'b1;
        #1;
        check("hit_count", hit_count, m_hits);
        check("miss_count", miss_count, m_misses);
        check("iREN_idle", iREN, 0);
        check("ihit", ihit, exp_hit);
        was_hit = ihit;
        if (exp_hit) begin
            check("imemload_hit", imemload, mem_word({addr[31:2], 2'b00}));
            m_hits++;
            @(posedge CLK);
            return;
        end
        check("imemload_miss", imemload, 0);
        m_misses++;
        exp_q.push_back(blk);
        exp_q.push_back(blk + 32'd4);
        @(posedge CLK);
        for (int k = 0; k < 2; k++) begin
            w = (k == 0) ? w0 : w1;
            for (int c = 0; c <= w; c++) begin
                @(negedge CLK);
                iwait = (c < w);
                if (k == 0 && c == 0 && mode == 1) imemaddr = alt;
                if (k == 0 && c == 0 && mode == 2) imemREN = 1'b0;
                #1;
                check("iREN_fetch", iREN, 1);
                check("ihit_fetch", ihit, 0);
                check("imemload_fetch", imemload, 0);
                if (c < w) begin
                    check("iaddr_wait", iaddr, blk + 32'(4 * k));
                end else begin
                    exp_a = exp_q.pop_front();
                    check("iaddr", iaddr, exp_a);
                end
                @(posedge CLK);
            end
        end
        m_valid[idx] = 1'b1;
        m_tag[idx]   = tag;
        if (mode == 0) begin
            @(negedge CLK);
            iwait = 1'b1;
            #1;
            check("ihit_after_fill", ihit, 1);
            check("imemload_after_fill", imemload, mem_word({addr[31:2], 2'b00}));
            check("iREN_after_fill", iREN, 0);
            check("iaddr_after_fill", iaddr, 0);
            m_hits++;
            @(posedge CLK);
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit          h;
        logic [31:0] a;
        logic [31:0] alt;
        int          mode;

        // Vectors: addr, w0, w1, mode, alt, expected hit, miss_count afterwards.
        // 0x000/0x080/0x100/0x200 all map to index 0 with different tags.
        vecs[0]  = '{32'h0000_0004, 2, 2, 0, 32'h0, 1'b0, 1};
        vecs[1]  = '{32'h0000_0000, 0, 0, 0, 32'h0, 1'b1, 1};
        vecs[2]  = '{32'h0000_0080, 0, 0, 0, 32'h0, 1'b0, 2};
        vecs[3]  = '{32'h0000_0000, 1, 0, 0, 32'h0, 1'b0, 3};
        vecs[4]  = '{32'h0000_0004, 0, 0, 0, 32'h0, 1'b1, 3};
        vecs[5]  = '{32'h0000_0100, 1, 2, 1, 32'h200, 1'b0, 4};
        vecs[6]  = '{32'h0000_0200, 0, 0, 0, 32'h0, 1'b0, 5};
        vecs[7]  = '{32'h0000_0100, 0, 0, 0, 32'h0, 1'b0, 6};
        vecs[8]  = '{32'h0000_0104, 0, 0, 0, 32'h0, 1'b1, 6};
        vecs[9]  = '{32'h0000_0148, 2, 0, 2, 32'h0, 1'b0, 7};
        vecs[10] = '{32'h0000_014F, 0, 0, 0, 32'h0, 1'b1, 7};

        // Reset state with a request pending.
        nRST     = 1'b0;
        imemREN  = 1'b1;
        imemaddr = 32'h40;
        iwait    = 1'b1;
        model_clear();
        for (int i = 0; i < 2; i++) begin
            @(negedge CLK);
            check("rst_ihit", ihit, 0);
            check("rst_imemload", imemload, 0);
            check("rst_iREN", iREN, 0);
            check("rst_iaddr", iaddr, 0);
            check("rst_hit_count", hit_count, 0);
            check("rst_miss_count", miss_count, 0);
        end
        nRST = 1'b1;
        #1;
        check("post_rst_ihit", ihit, 0);
        @(posedge CLK);
        @(negedge CLK);
        iwait = 1'b0;
        #1;
        check("post_rst_fsm_state", fsm_state, 2'd1);
        check("post_rst_iREN", iREN, 1);
        check("post_rst_iaddr0", iaddr, 32'h40);
        @(posedge CLK);
        @(negedge CLK);
        #1;
        check("post_rst_iaddr1", iaddr, 32'h44);
        @(posedge CLK);
        @(negedge CLK);
        iwait = 1'b1;
        #1;
        check("post_rst_fill_ihit", ihit, 1);
        check("post_rst_fill_data", imemload, 32'hAAAA_0040);
        apply_reset();

        // Directed vector table.
        for (int i = 0; i < 11; i++) begin
            do_fetch(vecs[i].addr, vecs[i].w0, vecs[i].w1, vecs[i].mode, vecs[i].alt, h);
            check($sformatf("vec%0d_hit", i), h, vecs[i].exp_hit);
            idle_cycle();
            check($sformatf("vec%0d_miss_count", i), miss_count, vecs[i].exp_mc);
        end

        // Randomized fetches over a small pool of 4 tags x 16 frames.
        for (int n = 0; n < 150; n++) begin
            if ($urandom_range(0, 7) == 0) begin
                idle_cycle();
            end else begin
                a    = (32'($urandom_range(0, 3)) << 7) | (32'($urandom_range(0, 15)) << 3)
                     | (32'($urandom_range(0, 1)) << 2) | 32'($urandom_range(0, 3));
                alt  = $urandom;
                mode = ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, 2)) : 0;
                do_fetch(a, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), mode, alt, h);
            end
        end

        // Reset during FETCH1, on an edge where the second word is delivered.
        @(negedge CLK);
        imemREN  = 1'b1;
        imemaddr = 32'h300;
        iwait    = 1'b1;
        #1;
        check("midfill_req_ihit", ihit, 0);
        @(posedge CLK);
        @(negedge CLK);
        iwait = 1'b0;
        #1;
        check("midfill_iaddr0", iaddr, 32'h300);
        @(posedge CLK);
        @(negedge CLK);
        nRST = 1'b0;
        #1;
        check("midfill_iaddr1", iaddr, 32'h304);
        @(posedge CLK);
        @(negedge CLK);
        nRST    = 1'b1;
        imemREN = 1'b0;
        iwait   = 1'b1;
        #1;
        check("midfill_iREN", iREN, 0);
        check("midfill_iaddr", iaddr, 0);
        check("midfill_hit_count", hit_count, 0);
        check("midfill_miss_count", miss_count, 0);
        check("midfill_fsm_state", fsm_state, 2'd0);
        model_clear();
        @(posedge CLK);
        do_fetch(32'h300, 0, 0, 0, 32'h0, h);
        check("midfill_refetch_hit", h, 0);
        do_fetch(32'h4, 1, 1, 0, 32'h0, h);
        check("midfill_other_hit", h, 0);
        idle_cycle();
        check("final_miss_count", miss_count, 2);
        check("final_hit_count", hit_count, 2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
